// File: rtl/bm_and_arbiter_if.sv
// Request/result bus shared by the requesters, the AND sequencer and the result consumer.
// The slave modport is the sequencer side; the master modport is the requester/consumer side.
interface bm_and_arbiter_if #(
  parameter int BITS = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*BITS-1:0] req_a;
  logic [NREQ*BITS-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic [BITS-1:0]      res_data;
  logic [IDW-1:0]       res_id;
  logic                 res_ready;
  logic                 busy;
  logic [CNTW-1:0]      op_count;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy, op_count
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy, op_count
  );
endinterface

// File: rtl/bm_and_arbiter.sv
// Round-robin sequencer sharing one registered bitwise-AND unit among NREQ requesters.
// One operation in flight; the tagged result is held until the consumer takes it.
module bm_and_arbiter #(
  parameter int BITS = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  bm_and_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_HOLD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id_p0;
  logic [IDW-1:0]  r_res_id_p1;
  logic [BITS-1:0] r_op_a_p0;
  logic [BITS-1:0] r_op_b_p0;
  logic [BITS-1:0] r_res_data_p1;
  logic            r_res_valid_p1;
  logic [CNTW-1:0] r_op_count;

  logic            w_grant_any;
  logic [IDW-1:0]  w_grant_id;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_rr_nxt;
  logic            w_accept;
  logic            w_exec;
  logic            w_done;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) begin
        w_grant_any = 1'b1;
        w_grant_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_any) begin
          w_grant[w_grant_id] = 1'b1;
          w_state_nxt         = ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_HOLD;
      ST_HOLD: if (bus.res_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && w_grant_any;
  assign w_exec   = (r_state == ST_EXEC);
  assign w_done   = (r_state == ST_HOLD) && bus.res_ready;
  assign w_rr_nxt = (r_res_id_p1 == IDW'(NREQ - 1)) ? '0 : r_res_id_p1 + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Stage p0: grant edge samples the winner's operands and id.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_op_a_p0 <= bus.req_a[w_grant_id*BITS +: BITS];
      r_op_b_p0 <= bus.req_b[w_grant_id*BITS +: BITS];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_id_p0        <= '0;
      r_res_id_p1    <= '0;
      r_res_data_p1  <= '0;
      r_res_valid_p1 <= 1'b0;
      r_rr_ptr       <= '0;
      r_op_count     <= '0;
    end else begin
      if (w_accept) r_id_p0 <= w_grant_id;
      // Stage p1: AND result is registered and held until the consumer accepts it.
      if (w_exec) begin
        r_res_data_p1  <= r_op_a_p0 & r_op_b_p0;
        r_res_id_p1    <= r_id_p0;
        r_res_valid_p1 <= 1'b1;
      end else if (w_done) begin
        r_res_valid_p1 <= 1'b0;
        r_rr_ptr       <= w_rr_nxt;
        r_op_count     <= r_op_count + 1'b1;
      end
    end
  end

  // Grants are suppressed combinationally while reset is held.
  assign bus.req_ready = reset_n ? w_grant : '0;
  assign bus.res_valid = r_res_valid_p1;
  assign bus.res_data  = r_res_data_p1;
  assign bus.res_id    = r_res_id_p1;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_bm_and_arbiter.sv
// Directed bench for bm_and_arbiter: reset, single op, round-robin order, backpressure,
// operand stability after grant and asynchronous reset during HOLD.
module tb_bm_and_arbiter;
  localparam int BITS = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bm_and_arbiter_if #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) bus ();

  bm_and_arbiter #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    bus.req_a[i*BITS +: BITS] = a;
    bus.req_b[i*BITS +: BITS] = b;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.req_valid = 4'b1111;
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.op_count !== 16'd0) begin failures++; $display("FAIL rst_op_count got=%0d exp=0", bus.op_count); end
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL idle_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL idle_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.op_count !== 16'd0) begin failures++; $display("FAIL idle_op_count got=%0d exp=0", bus.op_count); end
  endtask

  task automatic test_single();
    set_op(2, 32'hF0F0_1234, 32'hFF00_FF0F);
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", bus.req_ready); end
    step();
    bus.req_valid = '0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy_exec got=%b exp=1", bus.busy); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_valid_exec got=%b exp=0", bus.res_valid); end
    step();
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL single_res_valid got=%b exp=1", bus.res_valid); end
    checks++; if (bus.res_data !== 32'hF000_1204) begin failures++; $display("FAIL single_res_data got=%h exp=f0001204", bus.res_data); end
    checks++; if (bus.res_id !== 2'd2) begin failures++; $display("FAIL single_res_id got=%0d exp=2", bus.res_id); end
    step();
    checks++; if (bus.op_count !== 16'd1) begin failures++; $display("FAIL single_op_count got=%0d exp=1", bus.op_count); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL single_valid_after got=%b exp=0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", bus.busy); end
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL single_next_ptr got=%b exp=1000", bus.req_ready); end
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int last_cyc;
    logic [BITS-1:0] exp_data;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h1111_1111 * (i + 1), 32'hFFFF_FFFF);
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b1111;
    last_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      int t;
      t = 0;
      while (!bus.res_valid && t < 12) begin
        step();
        t++;
      end
      checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL rr_timeout result=%0d got_valid=%b exp=1", n, bus.res_valid); end
      exp_data = 32'h1111_1111 * ((n % NREQ) + 1);
      checks++; if (bus.res_id !== IDW'(n % NREQ)) begin failures++; $display("FAIL rr_id result=%0d got=%0d exp=%0d", n, bus.res_id, n % NREQ); end
      checks++; if (bus.res_data !== exp_data) begin failures++; $display("FAIL rr_data result=%0d got=%h exp=%h", n, bus.res_data, exp_data); end
      if (n > 0) begin
        checks++; if (cyc - last_cyc != 3) begin failures++; $display("FAIL rr_spacing result=%0d got=%0d exp=3", n, cyc - last_cyc); end
      end
      last_cyc = cyc;
      step();
    end
    bus.req_valid = '0;
    checks++; if (bus.op_count !== 16'd5) begin failures++; $display("FAIL rr_op_count got=%0d exp=5", bus.op_count); end
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    set_op(1, 32'hA5A5_5A5A, 32'h0FF0_F00F);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); end
    step();
    bus.req_valid = 4'b1111;
    step();
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cycle=%0d got=%b exp=1", c, bus.res_valid); end
      checks++; if (bus.res_data !== 32'h05A0_500A) begin failures++; $display("FAIL bp_data cycle=%0d got=%h exp=05a0500a", c, bus.res_data); end
      checks++; if (bus.res_id !== 2'd1) begin failures++; $display("FAIL bp_id cycle=%0d got=%0d exp=1", c, bus.res_id); end
      checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_req_ready cycle=%0d got=%b exp=0000", c, bus.req_ready); end
      step();
    end
    bus.res_ready = 1'b1;
    step();
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.op_count !== 16'd6) begin failures++; $display("FAIL bp_release_count got=%0d exp=6", bus.op_count); end
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL bp_next_grant got=%b exp=0100", bus.req_ready); end
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL bp_busy_after got=%b exp=0", bus.busy); end
    checks++; if (bus.op_count !== 16'd6) begin failures++; $display("FAIL bp_single_transfer got=%0d exp=6", bus.op_count); end
  endtask

  task automatic test_operand_change();
    set_op(2, 32'h1234_5678, 32'hFFFF_0000);
    bus.req_valid = 4'b0100;
    bus.res_ready = 1'b1;
    step();
    bus.req_a[2*BITS +: BITS] = 32'h0000_0000;
    bus.req_valid = '0;
    step();
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL opchg_valid got=%b exp=1", bus.res_valid); end
    checks++; if (bus.res_data !== 32'h1234_0000) begin failures++; $display("FAIL opchg_data got=%h exp=12340000", bus.res_data); end
    checks++; if (bus.res_id !== 2'd2) begin failures++; $display("FAIL opchg_id got=%0d exp=2", bus.res_id); end
    step();
    checks++; if (bus.op_count !== 16'd7) begin failures++; $display("FAIL opchg_count got=%0d exp=7", bus.op_count); end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    set_op(0, 32'hFFFF_FFFF, 32'h0000_FFFF);
    bus.req_valid = 4'b0001;
    bus.res_ready = 1'b0;
    step();
    bus.req_valid = '0;
    step();
    checks++; if (bus.res_valid !== 1'b1) begin failures++; $display("FAIL mid_hold_valid got=%b exp=1", bus.res_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_async_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.op_count !== 16'd0) begin failures++; $display("FAIL mid_async_count got=%0d exp=0", bus.op_count); end
    checks++; if (bus.res_data !== 32'h0) begin failures++; $display("FAIL mid_async_data got=%h exp=0", bus.res_data); end
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0000", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL mid_first_grant got=%b exp=0001", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_idle got=%b exp=0", bus.busy); end
    step();
    bus.req_valid = '0;
    step();
    checks++; if (bus.res_id !== 2'd0) begin failures++; $display("FAIL mid_res_id got=%0d exp=0", bus.res_id); end
    checks++; if (bus.res_data !== 32'h0000_FFFF) begin failures++; $display("FAIL mid_res_data got=%h exp=0000ffff", bus.res_data); end
    bus.res_ready = 1'b1;
    step();
    checks++; if (bus.op_count !== 16'd1) begin failures++; $display("FAIL mid_op_count got=%0d exp=1", bus.op_count); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_operand_change();
    test_reset_mid_op();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
